restoring_div8: RTL and testbench
=================================

RESTORING_DIV8 -- requirements
Module: restoring_div8

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Port clk  input  1  system clock, all state on rising edge.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port start  input  1  request to begin a division, sampled on rising clk.
REQ-005 Port Dividend  input  8  unsigned dividend, sampled with start.
REQ-006 Port Divisor  input  8  unsigned divisor, sampled with start.
REQ-007 Port Quotient  output  8  registered unsigned quotient of last completed operation.
REQ-008 Port Remainder  output  8  registered unsigned remainder of last completed operation.
REQ-009 Port busy  output  1  high while iterating.
REQ-010 Port done  output  1  one-cycle pulse, Quotient/Remainder/div_by_zero valid for this operation.
REQ-011 Port div_by_zero  output  1  registered flag: last completed operation had Divisor = 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in BUSY SHALL be ignored with no effect on state or operands.
REQ-014 On accepted start with Divisor != 0 at edge k, the block SHALL latch Dividend into an internal quotient shift register Q, Divisor into D, clear an internal 8-bit partial remainder R, clear a 3-bit iteration counter, and enter BUSY.
REQ-015 Each BUSY cycle SHALL perform one restoring step: form T = {R, Q[7]} - {1'b0, D} in 9 bits; if T has no borrow (T[8]=0) then R <= T[7:0], Q <= {Q[6:0], 1}; else R <= {R[6:0], Q[7]}, Q <= {Q[6:0], 0}.
REQ-016 Exactly 8 steps SHALL occur, on edges k+1..k+8; at edge k+8 the FSM SHALL enter DONE and Quotient, Remainder SHALL load the final Q, R, div_by_zero SHALL load 0.
REQ-017 done SHALL be high exactly while in DONE (between edges k+8 and k+9); busy SHALL be high exactly while in BUSY (between edges k and k+8).
REQ-018 From DONE without start the FSM SHALL return to IDLE at the next edge; with start the new operation SHALL be accepted at that edge (back-to-back), done falling and busy rising together.
REQ-019 On accepted start with Divisor = 0, the block SHALL skip BUSY and enter DONE at the same edge k, loading Quotient = 8'hFF, Remainder = Dividend, div_by_zero = 1; latency 1 cycle.
REQ-020 Quotient, Remainder, div_by_zero SHALL hold their values from the last DONE entry until the next DONE entry; they SHALL NOT change during BUSY.
REQ-021 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor for all 65280 nonzero-divisor operand pairs.
REQ-022 Input changes on Dividend/Divisor after the accepting edge SHALL NOT affect the operation in progress.

Reset
REQ-023 Asserting rst SHALL immediately, without clk, force state IDLE, counter 0, R/Q/D 0, Quotient 0, Remainder 0, busy 0, done 0, div_by_zero 0.
REQ-024 Reset during BUSY or DONE SHALL abandon the operation; no done pulse SHALL follow deassertion.
REQ-025 While rst is high start SHALL be ignored; first acceptance is possible at the first rising edge with rst low.

Verification
REQ-026 Dividend=200, Divisor=7, start at edge k -> busy high k..k+8, done high k+8..k+9, Quotient=28, Remainder=4, div_by_zero=0.
REQ-027 Corner pairs 255/1 -> 255 r0; 5/9 -> 0 r5; 0/3 -> 0 r0; 255/255 -> 1 r0; 128/2 -> 64 r0, each with 8-cycle latency.
REQ-028 Dividend=77, Divisor=0 -> done at edge k (one cycle), Quotient=8'hFF, Remainder=77, div_by_zero=1; a following 9/3 clears div_by_zero to 0 with Quotient=3.
REQ-029 start pulsed with 50/5 mid-BUSY of 100/3 -> ignored; result 33 r1, single done pulse.
REQ-030 rst asserted asynchronously at k+4 of an operation -> all outputs 0 immediately, no done; next 17/4 after deassertion -> 4 r1.
REQ-031 start held high continuously with changing operands -> back-to-back operations every 9 cycles, each done pulse carrying the correct result for operands sampled at its accepting edge.

Source files
------------

// File: rtl/restoring_div8.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// eight BUSY cycles per operation, with a one-cycle bypass for a zero divisor.
module restoring_div8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [7:0] r_q, q_q, d_q;
  logic [7:0] quot_q, rem_q;
  logic       busy_q, done_q, dbz_q;

  logic [8:0] t_d;
  logic [7:0] r_d, q_d;

  // One restoring step: trial-subtract the divisor from the shifted remainder
  // and keep the difference only when it does not borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r_d = {r_q[6:0], q_q[7]};
    q_d = {q_q[6:0], 1'b0};
    t_d = {r_q, q_q[7]} - {1'b0, d_q};
    if (!t_d[8]) begin
      r_d = t_d[7:0];
      q_d = {q_q[6:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (Divisor == 8'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= 8'hFF;
              rem_q   <= Dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              q_q     <= Dividend;
              d_q     <= Divisor;
              r_q     <= '0;
              cnt_q   <= '0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 3'd1;
          // The eighth step's result goes straight to the output registers.
          if (cnt_q == 3'd7) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Quotient    = quot_q;
  assign Remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div8.sv
// Directed bench for restoring_div8: table of single operations plus
// hand-written sequences for ignored start, async reset and back-to-back runs.
module tb_restoring_div8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] Dividend, Divisor;
  logic [7:0] Quotient, Remainder;
  logic       busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;

  restoring_div8 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Waits (bounded) for done after the accepting edge; returns edges counted
  // after that edge and the number of samples where busy was unexpectedly low.
  task automatic wait_done(output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int n, bb;
    @(negedge clk);
    start = 1'b1; Dividend = v.a; Divisor = v.b;
    @(posedge clk); #1;
    start = 1'b0; Dividend = ~v.a; Divisor = v.b ^ 8'h5A;
    wait_done(n, bb);
    check({nm, " latency"}, n, v.lat);
    check({nm, " busy during op"}, bb, 0);
    check({nm, " busy at done"}, busy, 1'b0);
    check({nm, " quotient"}, Quotient, v.q);
    check({nm, " remainder"}, Remainder, v.r);
    check({nm, " div_by_zero"}, div_by_zero, v.z);
    @(posedge clk); #1;
    check({nm, " done one cycle"}, done, 1'b0);
    check({nm, " result held"}, {Quotient, Remainder}, {v.q, v.r});
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bb, dcount;
    vec_t v;
    vec_t bb_ops[4];

    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
    vecs[3]  = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8};
    vecs[4]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
    vecs[5]  = '{8'd128, 8'd2,   8'd64,  8'd0,  1'b0, 8};
    vecs[6]  = '{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 0};
    vecs[7]  = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 8};
    vecs[8]  = '{8'd13,  8'd200, 8'd0,   8'd13, 1'b0, 8};
    vecs[9]  = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0, 8};
    vecs[10] = '{8'd250, 8'd16,  8'd15,  8'd10, 1'b0, 8};

    rst = 1'b1; start = 1'b0; Dividend = 8'd0; Divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {Quotient, Remainder, busy, done, div_by_zero}, 19'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      do_op(vecs[i], $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));

    // Start pulse with 50/5 in the middle of 100/3 must be ignored.
    @(negedge clk);
    start = 1'b1; Dividend = 8'd100; Divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    @(posedge clk); #1;
    n = 4;
    start = 1'b0;
    check("ignored start busy", busy, 1'b1);
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignored start latency", n, 8);
    check("ignored start result", {Quotient, Remainder}, {8'd33, 8'd1});
    dcount = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    check("ignored start single done", dcount, 1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; Dividend = 8'd250; Divisor = 8'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset outputs", {Quotient, Remainder, busy, done, div_by_zero}, 19'd0);
    start = 1'b1; Dividend = 8'd17; Divisor = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    check("start ignored in reset", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    check("no activity after reset", dcount, 0);
    v = '{8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 8};
    do_op(v, "post reset 17/4");

    // start held high: back-to-back operations every 9 cycles.
    bb_ops[0] = '{8'd200, 8'd7,  8'd28, 8'd4,  1'b0, 8};
    bb_ops[1] = '{8'd99,  8'd10, 8'd9,  8'd9,  1'b0, 8};
    bb_ops[2] = '{8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8};
    bb_ops[3] = '{8'd1,   8'd1,  8'd1,  8'd0,  1'b0, 8};
    @(negedge clk);
    start = 1'b1; Dividend = bb_ops[0].a; Divisor = bb_ops[0].b;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        Dividend = bb_ops[i+1].a; Divisor = bb_ops[i+1].b;
      end
      wait_done(n, bb);
      check($sformatf("b2b%0d latency", i), n, 8);
      check($sformatf("b2b%0d busy", i), bb, 0);
      check($sformatf("b2b%0d result", i), {Quotient, Remainder}, {bb_ops[i].q, bb_ops[i].r});
      if (i == 3) start = 1'b0;
      @(posedge clk); #1;
      check($sformatf("b2b%0d next state", i), {busy, done}, (i < 3) ? 2'b10 : 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
